// File: rtl/vblank_access_arbiter.sv
// ============================================================================
// Module   : vblank_access_arbiter
// Brief    : Grants the board-RAM write port to one requester at a time, only
//            during vertical blanking. Also emits frame_tick and step_tick.
//            Optional macro ARB_FIXED_PRIO_EN selects fixed lowest-index
//            priority instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vblank_access_arbiter #(
    parameter int NREQ            = 3,
    parameter int IDW             = 2,
    parameter int MAX_BURST       = 16,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            vblnk,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic            frame_tick,
    output logic            step_tick,
    output logic            overrun,
    input  logic            clr_overrun
);

    localparam logic [7:0] c_burst_last = 8'(MAX_BURST - 1);
    localparam logic [7:0] c_frame_last = 8'(FRAMES_PER_STEP - 1);
    localparam logic [IDW:0] c_nreq     = (IDW+1)'(NREQ);

    typedef enum logic [1:0] {
        S_VIDEO = 2'd0,
        S_ARB   = 2'd1,
        S_GNT   = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_vblnk_q;
    logic [7:0]      r_frame_cnt;
    logic [7:0]      r_burst;
    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_gnt_id;
    logic            r_busy;
    logic            r_frame_tick;
    logic            r_step_tick;
    logic            r_overrun;

    logic            w_rise;
    logic            w_req_held;
    logic            w_release;
    logic            w_overrun_set;
    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_win_off;
    logic [IDW:0]    w_win_sum;
    logic [IDW-1:0]  w_win_id;
    logic [IDW:0]    w_ptr_sum;
    logic [IDW-1:0]  w_next_ptr;

    assign w_rise     = vblnk & ~r_vblnk_q;
    // gnt is one-hot, so masking req with it yields req[gnt_id]
    assign w_req_held = |(req & r_gnt);
    assign w_release  = ~w_req_held | (r_burst == c_burst_last) | ~vblnk;
    assign w_overrun_set = (r_state == S_GNT) & ~vblnk & w_req_held;

    // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
    assign w_rot = NREQ'({req, req} >> r_ptr);

    always_comb begin
        w_win_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_win_off = IDW'(i);
            end
        end
    end

    assign w_win_sum  = {1'b0, r_ptr} + {1'b0, w_win_off};
    assign w_win_id   = (w_win_sum >= c_nreq) ? IDW'(w_win_sum - c_nreq) : IDW'(w_win_sum);
    assign w_ptr_sum  = {1'b0, r_gnt_id} + {{IDW{1'b0}}, 1'b1};
    assign w_next_ptr = (w_ptr_sum >= c_nreq) ? '0 : IDW'(w_ptr_sum);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk_q    <= 1'b0;
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
            r_step_tick  <= 1'b0;
        end else begin
            r_vblnk_q    <= vblnk;
            r_frame_tick <= w_rise;
            if (w_rise && (r_frame_cnt == c_frame_last)) begin
                r_step_tick <= 1'b1;
                r_frame_cnt <= '0;
            end else begin
                r_step_tick <= 1'b0;
                if (w_rise) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_VIDEO;
            r_ptr     <= '0;
            r_burst   <= '0;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_VIDEO: begin
                    r_gnt    <= '0;
                    r_gnt_id <= '0;
                    r_busy   <= 1'b0;
                    if (w_rise) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (!vblnk) begin
                        r_state <= S_VIDEO;
                    end else if (|req) begin
                        r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_win_id;
                        r_gnt_id <= w_win_id;
                        r_busy   <= 1'b1;
                        r_burst  <= '0;
                        r_state  <= S_GNT;
                    end
                end
                S_GNT: begin
                    if (w_release) begin
                        r_gnt    <= '0;
                        r_gnt_id <= '0;
                        r_busy   <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
                        r_ptr    <= '0;
`else
                        r_ptr    <= w_next_ptr;
`endif
                        r_state  <= vblnk ? S_ARB : S_VIDEO;
                    end else begin
                        r_burst <= r_burst + 8'd1;
                    end
                end
                default: begin
                    r_gnt    <= '0;
                    r_gnt_id <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= S_VIDEO;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign gnt_id     = r_gnt_id;
    assign busy       = r_busy;
    assign frame_tick = r_frame_tick;
    assign step_tick  = r_step_tick;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_vblank_access_arbiter.sv
// ============================================================================
// Module   : tb_vblank_access_arbiter
// Brief    : Scoreboard bench for vblank_access_arbiter (NREQ=3, MAX_BURST=4,
//            FRAMES_PER_STEP=2); honours ARB_FIXED_PRIO_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vblank_access_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit c_fixed = 1'b1;
`else
    localparam bit c_fixed = 1'b0;
`endif

    logic       pclk;
    logic       rst_n;
    logic       vblnk;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       frame_tick;
    logic       step_tick;
    logic       overrun;
    logic       clr_overrun;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         ev_idx   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_act;
    logic [8:0] mon_exp;
    logic       prev_ovr = 1'b0;
    logic [1:0] s2_id;

    vblank_access_arbiter #(
        .NREQ(3), .IDW(2), .MAX_BURST(4), .FRAMES_PER_STEP(2)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vblnk(vblnk), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
        .frame_tick(frame_tick), .step_tick(step_tick),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Record layout: {gnt[2:0], gnt_id[1:0], busy, frame_tick, step_tick, overrun}
    function automatic logic [8:0] cur();
        return {gnt, gnt_id, busy, frame_tick, step_tick, overrun};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got gnt/id/busy/ft/st/ovr=%b required %b", name, act, expv);
    endtask

    task automatic push(input logic [2:0] g, input logic [1:0] id, input logic ft,
                        input logic st, input logic ov, input int n = 1);
        for (int i = 0; i < n; i++) exp_q.push_back({g, id, |g, ft, st, ov});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Monitor: any cycle with a grant, a tick, or an overrun change is an output event.
    always @(negedge pclk) begin
        mon_act = cur();
        if ((gnt != 3'b000) || frame_tick || step_tick || (overrun != prev_ovr)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event%0d: got %b required no event", ev_idx, mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                check($sformatf("event%0d", ev_idx), mon_act, mon_exp);
            end
            ev_idx++;
        end
        prev_ovr = overrun;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; vblnk = 1'b0; req = 3'b000; clr_overrun = 1'b0;
        cyc(3);
        check("reset_outputs", cur(), 9'd0);
        rst_n = 1'b1;
        cyc(2);

        // Empty windows: frame_tick each frame, step_tick every second one.
        for (int k = 1; k <= 6; k++) begin
            push(3'b000, 2'd0, 1'b1, (k % 2 == 0), 1'b0);
            vblnk = 1'b1; cyc(3);
            vblnk = 1'b0; cyc(3);
        end

        // All requesters held for the window; vblnk falls mid-grant.
        push(3'b000, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            s2_id = c_fixed ? 2'd0 : 2'(g);
            push(3'b001 << s2_id, s2_id, 1'b0, 1'b0, 1'b0, 4);
        end
        push(3'b001, 2'd0, 1'b0, 1'b0, 1'b0);
        push(3'b000, 2'd0, 1'b0, 1'b0, 1'b1);
        push(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
        vblnk = 1'b1; req = 3'b111; cyc(17);
        vblnk = 1'b0; cyc(1);
        req = 3'b000; cyc(1);
        clr_overrun = 1'b1; cyc(1);
        clr_overrun = 1'b0; cyc(3);

        // Short req[1] pulse, then req=011 starts from the rotated pointer.
        push(3'b000, 2'd0, 1'b1, 1'b1, 1'b0);
        push(3'b010, 2'd1, 1'b0, 1'b0, 1'b0, 2);
        push(3'b001, 2'd0, 1'b0, 1'b0, 1'b0, 4);
        vblnk = 1'b1; req = 3'b000; cyc(1);
        req = 3'b010; cyc(2);
        req = 3'b000; cyc(1);
        req = 3'b011; cyc(4);
        req = 3'b000; cyc(2);
        vblnk = 1'b0; cyc(3);

        // Request during active video waits for the window; vblnk falls mid-grant.
        push(3'b000, 2'd0, 1'b1, 1'b0, 1'b0);
        push(3'b001, 2'd0, 1'b0, 1'b0, 1'b0);
        push(3'b000, 2'd0, 1'b0, 1'b0, 1'b1);
        push(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
        req = 3'b001; cyc(4);
        vblnk = 1'b1; cyc(2);
        vblnk = 1'b0; cyc(1);
        clr_overrun = 1'b1; cyc(1);
        clr_overrun = 1'b0; req = 3'b000; cyc(3);

        // Reset asserted mid-grant drops gnt without waiting for a clock.
        push(3'b000, 2'd0, 1'b1, 1'b1, 1'b0);
        push(3'b001, 2'd0, 1'b0, 1'b0, 1'b0);
        vblnk = 1'b1; req = 3'b001; cyc(3);
        rst_n = 1'b0; #1;
        check("async_reset_drop", cur(), 9'd0);
        vblnk = 1'b0; req = 3'b000; cyc(2);
        rst_n = 1'b1; cyc(2);

        // Overrun set and clear in the same cycle: set wins, then clear.
        push(3'b000, 2'd0, 1'b1, 1'b0, 1'b0);
        push(3'b001, 2'd0, 1'b0, 1'b0, 1'b0);
        push(3'b000, 2'd0, 1'b0, 1'b0, 1'b1);
        push(3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
        vblnk = 1'b1; req = 3'b001; cyc(2);
        vblnk = 1'b0; clr_overrun = 1'b1; cyc(2);
        clr_overrun = 1'b0; req = 3'b000; cyc(3);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drained: got %0d pending events required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
